// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the cache mem_req/mem_resp interface. It stands in
// for DRAM in simulation and FPGA builds: a 2**DEPTH_BITS x MEM_DATA_BITS
// backing array that accepts one read or byte-masked write per handshake and
// returns reads as a fixed BEATS-long, critical-word-first burst after
// READ_LATENCY cycles.
//
// Ports
//   clk                 in   clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   mem_req_valid       in   request command valid
//   mem_req_ready       out  command accepted when high (only in IDLE)
//   mem_req_addr        in   beat address; bits above DEPTH_BITS alias
//   mem_req_rw          in   1 = write, 0 = read
//   mem_req_data_valid  in   write data valid
//   mem_req_data_ready  out  write data accepted when high (only in IDLE)
//   mem_req_data_bits   in   write data
//   mem_req_data_mask   in   byte enables, bit i -> byte i
//   mem_resp_valid      out  read beat valid (no backpressure)
//   mem_resp_data       out  read beat data, zero when mem_resp_valid is low
//
// Build option
//   MEM_RESP_GAP_EN : when defined, one idle cycle is inserted after every
//                     read beat except the last, so a burst spans 2*BEATS-1
//                     cycles. Beat order is unchanged. Undefined (default):
//                     beats are back-to-back.
//
// MEM_DATA_BITS is taken from the surrounding build; it defaults to 128.
// -----------------------------------------------------------------------------
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_responder #(
   parameter int MEM_ADDR_BITS = 28,
   parameter int DEPTH_BITS    = 12,
   parameter int READ_LATENCY  = 4,   // 1..15
   parameter int BEATS         = 4    // power of two, 2..4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          mem_req_valid,
   output logic                          mem_req_ready,
   input  logic [MEM_ADDR_BITS-1:0]      mem_req_addr,
   input  logic                          mem_req_rw,
   input  logic                          mem_req_data_valid,
   output logic                          mem_req_data_ready,
   input  logic [`MEM_DATA_BITS-1:0]     mem_req_data_bits,
   input  logic [`MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
   output logic                          mem_resp_valid,
   output logic [`MEM_DATA_BITS-1:0]     mem_resp_data
);

   localparam int DATA_W    = `MEM_DATA_BITS;
   localparam int MASK_W    = DATA_W / 8;
   localparam int DEPTH     = 1 << DEPTH_BITS;
   localparam int BEAT_BITS = $clog2(BEATS);
   localparam int CNT_W     = BEAT_BITS + 1;

   // beat_cnt runs 0..BEATS; the value BEATS marks the cycle in which the
   // last beat is on the output, so ready stays low until that beat is gone.
   localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEATS - 1);
   localparam logic [3:0]       LAT_LOAD  = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_LAT   = 2'd1,
      RD_BURST = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              lat_cnt_q, lat_cnt_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [DEPTH_BITS-1:0]   addr_q, addr_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]       resp_data_q, resp_data_d;
`ifdef MEM_RESP_GAP_EN
   logic                    gap_q, gap_d;
`endif

   logic [DATA_W-1:0]       mem [DEPTH];

   logic                    idle;
   logic                    wr_fire;
   logic                    rd_fire;
   logic [DEPTH_BITS-1:0]   wr_idx;
   logic [BEAT_BITS-1:0]    wrap_off;
   logic [DEPTH_BITS-1:0]   beat_idx;
   logic                    unused_addr_hi;

   // Upper address bits alias onto the array and are deliberately dropped.
   assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

   assign idle    = (state_q == IDLE);
   assign wr_fire = idle && mem_req_valid && mem_req_rw && mem_req_data_valid;
   assign rd_fire = idle && mem_req_valid && !mem_req_rw;
   assign wr_idx  = mem_req_addr[DEPTH_BITS-1:0];

   // Critical-word-first: only the low BEAT_BITS advance, so the burst wraps
   // inside the aligned BEATS-block holding the requested word.
   assign wrap_off = addr_q[BEAT_BITS-1:0] + beat_cnt_q[BEAT_BITS-1:0];
   assign beat_idx = {addr_q[DEPTH_BITS-1:BEAT_BITS], wrap_off};

   assign mem_req_ready      = idle;
   assign mem_req_data_ready = idle;
   assign mem_resp_valid     = resp_valid_q;
   assign mem_resp_data      = resp_data_q;

   // -------------------------------------------------------------------------
   // Next-state and response data
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      addr_d       = addr_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
`ifdef MEM_RESP_GAP_EN
      gap_d        = gap_q;
`endif

      case (state_q)
         IDLE: begin
            if (rd_fire) begin
               addr_d     = mem_req_addr[DEPTH_BITS-1:0];
               beat_cnt_d = '0;
`ifdef MEM_RESP_GAP_EN
               gap_d      = 1'b0;
`endif
               // The first beat is registered out of RD_BURST, so the burst
               // state must begin one cycle before the beat is due.
               if (READ_LATENCY == 1) begin
                  state_d = RD_BURST;
               end else begin
                  state_d   = RD_LAT;
                  lat_cnt_d = LAT_LOAD;
               end
            end
         end

         RD_LAT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q == 4'd1) begin
               state_d = RD_BURST;
            end
         end

         RD_BURST: begin
            if (beat_cnt_q == CNT_DRAIN) begin
               state_d = IDLE;
`ifdef MEM_RESP_GAP_EN
            end else if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               resp_valid_d = 1'b1;
               resp_data_d  = mem[beat_idx];
               beat_cnt_d   = beat_cnt_q + 1'b1;
               gap_d        = (beat_cnt_q != CNT_LAST);
            end
`else
            end else begin
               resp_valid_d = 1'b1;
               resp_data_d  = mem[beat_idx];
               beat_cnt_d   = beat_cnt_q + 1'b1;
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control and response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         beat_cnt_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
`ifdef MEM_RESP_GAP_EN
         gap_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
`ifdef MEM_RESP_GAP_EN
         gap_q        <= gap_d;
`endif
      end
   end

   // Latched read address carries no reset; it is only consumed after a
   // read has been accepted.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
   end

   // -------------------------------------------------------------------------
   // Backing array: byte-masked writes, contents survive reset
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (mem_req_data_mask[b]) begin
               mem[wr_idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int AW    = 28;
   localparam int DB    = 12;
   localparam int BEATS = 4;
`ifdef MEM_RESP_GAP_EN
   localparam int          LAT  = 1;
   localparam int          PLEN = 7;
   localparam logic [6:0]  PAT  = 7'b1010101;
`else
   localparam int          LAT  = 4;
   localparam int          PLEN = 4;
   localparam logic [6:0]  PAT  = 7'b0001111;
`endif

   logic          clk;
   logic          reset_n;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_rw;
   logic          mem_req_data_valid;
   logic          mem_req_data_ready;
   logic [127:0]  mem_req_data_bits;
   logic [15:0]   mem_req_data_mask;
   logic          mem_resp_valid;
   logic [127:0]  mem_resp_data;

   mem_responder #(
      .MEM_ADDR_BITS (AW),
      .DEPTH_BITS    (DB),
      .READ_LATENCY  (LAT),
      .BEATS         (BEATS)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_addr       (mem_req_addr),
      .mem_req_rw         (mem_req_rw),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [127:0] model [0:4095];
   logic [127:0] exp_q [$];
   logic [127:0] mon_exp;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every valid beat must match the head of the queue,
   // and the data bus must be zero when no beat is valid.
   always @(negedge clk) begin
      if (mem_resp_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data %h, required no beat", mem_resp_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mem_resp_data !== mon_exp) begin
               errors++;
               $display("FAIL beat_data: got %h, required %h", mem_resp_data, mon_exp);
            end
         end
      end else begin
         checks++;
         if (mem_resp_data !== 128'd0) begin
            errors++;
            $display("FAIL idle_data: got %h, required 0", mem_resp_data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- drivers
   task automatic do_write(input logic [AW-1:0] a, input logic [127:0] d, input logic [15:0] m);
      mem_req_valid      = 1'b1;
      mem_req_rw         = 1'b1;
      mem_req_data_valid = 1'b1;
      mem_req_addr       = a;
      mem_req_data_bits  = d;
      mem_req_data_mask  = m;
      @(posedge clk);
      for (int b = 0; b < 16; b++)
         if (m[b]) model[a[11:0]][b*8 +: 8] = d[b*8 +: 8];
      #1;
      mem_req_valid      = 1'b0;
      mem_req_data_valid = 1'b0;
      mem_req_rw         = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (mem_req_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: ready=%b after %0d cycles, required 1", mem_req_ready, n);
      end
   endtask

   task automatic issue_read(input logic [AW-1:0] a);
      logic [1:0]  lo;
      logic [11:0] idx;
      wait_idle();
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = a;
      @(posedge clk); #1;
      accept_cyc = cyc;
      for (int i = 0; i < BEATS; i++) begin
         lo  = a[1:0] + 2'(i);
         idx = {a[11:2], lo};
         exp_q.push_back(model[idx]);
      end
      mem_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mem_req_ready !== 1'b1) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic preload_block(input logic [AW-1:0] base);
      for (int i = 0; i < BEATS; i++)
         do_write(base + AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'hFFFF);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", mem_req_ready); end
      checks++;
      if (mem_req_data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready: got %b, required 1", mem_req_data_ready); end
      checks++;
      if (mem_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, required 0", mem_resp_valid); end
      checks++;
      if (mem_resp_data !== 128'd0) begin errors++; $display("FAIL reset_resp_data: got %h, required 0", mem_resp_data); end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", mem_req_ready); end
   endtask

   task automatic test_write_read();
      int n;
      wait_idle();
      do_write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
      for (int i = 1; i < BEATS; i++)
         do_write(28'h10 + AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'hFFFF);
      issue_read(28'h10);
      n = 0;
      do begin @(negedge clk); n++; end while (mem_resp_valid !== 1'b1 && n < 50);
      checks++;
      if (cyc - accept_cyc != LAT) begin
         errors++;
         $display("FAIL read_latency: got %0d cycles, required %0d", cyc - accept_cyc, LAT);
      end
      wait_drain();
   endtask

   task automatic test_partial_mask();
      int n;
      wait_idle();
      for (int i = 0; i < BEATS; i++)
         do_write(28'h20 + AW'(i), {128{1'b1}}, 16'hFFFF);
      do_write(28'h20, 128'd0, 16'h000F);
      issue_read(28'h20);
      n = 0;
      do begin @(negedge clk); n++; end while (mem_resp_valid !== 1'b1 && n < 50);
      checks++;
      if (mem_resp_data !== {{96{1'b1}}, 32'h0}) begin
         errors++;
         $display("FAIL partial_mask: got %h, required %h", mem_resp_data, {{96{1'b1}}, 32'h0});
      end
      wait_drain();
   endtask

   task automatic test_wrap();
      int  beats;
      int  n;
      bit  low_ok;
      wait_idle();
      preload_block(28'h2C);
      issue_read(28'h2E);
      beats  = 0;
      n      = 0;
      low_ok = 1'b1;
      while (beats < BEATS && n < 100) begin
         @(negedge clk);
         n++;
         if (mem_req_ready !== 1'b0) low_ok = 1'b0;
         if (mem_resp_valid === 1'b1) beats++;
      end
      checks++;
      if (!low_ok) begin errors++; $display("FAIL wrap_ready_low: got ready=1 during burst, required 0"); end
      checks++;
      if (beats != BEATS) begin errors++; $display("FAIL wrap_beats: got %0d, required %0d", beats, BEATS); end
      @(negedge clk);
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_after: got %b, required 1", mem_req_ready); end
      wait_drain();
   endtask

   task automatic test_handshake();
      logic [127:0] keep;
      wait_idle();
      preload_block(28'h40);
      keep = model[12'h41];
      // Command without data: must not write.
      mem_req_valid      = 1'b1;
      mem_req_rw         = 1'b1;
      mem_req_data_valid = 1'b0;
      mem_req_addr       = 28'h40;
      mem_req_data_bits  = {4{32'hDEADBEEF}};
      mem_req_data_mask  = 16'hFFFF;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_wait_idle: data_ready=%b, required 1", mem_req_data_ready);
         end
      end
      // Data arrives on the fourth cycle: written now, lower half only.
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = 128'h0000_0000_0000_0000_A5A5_5A5A_C3C3_3C3C;
      mem_req_data_mask  = 16'h00FF;
      @(posedge clk);
      model[12'h40][63:0] = 64'hA5A5_5A5A_C3C3_3C3C;
      #1;
      // Data without command: must not write.
      mem_req_valid      = 1'b0;
      mem_req_addr       = 28'h41;
      mem_req_data_bits  = {4{32'hBAADF00D}};
      mem_req_data_mask  = 16'hFFFF;
      @(posedge clk); #1;
      mem_req_data_valid = 1'b0;
      mem_req_rw         = 1'b0;
      checks++;
      if (model[12'h41] !== keep) begin errors++; $display("FAIL hs_model: got %h, required %h", model[12'h41], keep); end
      issue_read(28'h40);
      wait_drain();
   endtask

   task automatic test_read_blocked();
      int n;
      wait_idle();
      issue_read(28'h10);
      n = 0;
      while (mem_req_ready !== 1'b1 && n < 100) begin
         mem_req_valid = 1'b1;
         mem_req_rw    = 1'b0;
         mem_req_addr  = 28'h20;
         @(posedge clk); #1;
         n++;
      end
      mem_req_valid = 1'b0;
      repeat (LAT + 2 * BEATS + 2) @(posedge clk);
      #1;
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL blocked_ready: got %b, required 1", mem_req_ready); end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL blocked_beats: %0d outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: write %0d ready=%b, required 1", i, mem_req_ready); end
         do_write(28'h60 + AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'hFFFF);
      end
      for (int i = 0; i < 4; i++)
         do_write(28'h60 + AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()));
      // Read accepted the cycle right after the last write.
      issue_read(28'h62);
      wait_drain();
      issue_read(28'h1067);
      wait_drain();
   endtask

   task automatic test_gap_pattern();
      int n;
      wait_idle();
      preload_block(28'h30);
      issue_read(28'h31);
      n = 0;
      do begin @(negedge clk); n++; end while (mem_resp_valid !== 1'b1 && n < 50);
      checks++;
      if (cyc - accept_cyc != LAT) begin
         errors++;
         $display("FAIL gap_latency: got %0d cycles, required %0d", cyc - accept_cyc, LAT);
      end
      for (int i = 0; i < PLEN; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (mem_resp_valid !== PAT[i] || mem_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL beat_pattern: cycle %0d valid=%b ready=%b, required valid=%b ready=0",
                     i, mem_resp_valid, mem_req_ready, PAT[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL pattern_ready_after: got %b, required 1", mem_req_ready); end
      wait_drain();
   endtask

   task automatic test_reset_mid_burst();
      int n;
      wait_idle();
      preload_block(28'h50);
      issue_read(28'h50);
      n = 0;
      do begin @(negedge clk); n++; end while (mem_resp_valid !== 1'b1 && n < 50);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b, required 1", mem_req_ready); end
      checks++;
      if (mem_resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", mem_resp_valid); end
      exp_q.delete();
      @(negedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (LAT + BEATS) @(posedge clk);
      #1;
      checks++;
      if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL burst_abandoned: ready=%b, required 1", mem_req_ready); end
      // Array contents survive reset.
      issue_read(28'h52);
      wait_drain();
   endtask

   initial begin
      mem_req_valid      = 1'b0;
      mem_req_addr       = '0;
      mem_req_rw         = 1'b0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = '0;
      mem_req_data_mask  = '0;
      test_reset();
      test_write_read();
      test_partial_mask();
      test_wrap();
      test_handshake();
      test_read_blocked();
      test_back_to_back();
      test_gap_pattern();
      test_reset_mid_burst();
      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
